dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and sequencer in front of the single-port data memory, which has a word-aligned address, a combinational read and a synchronous write. It grants the memory to one requester at a time using round-robin priority. It registers each transaction onto the memory port. Sub-word stores with byte enables are turned into a read-modify-write pair, because the memory only writes whole words.

## Interface
- `ADDR_W`, default 32: address width of the requester and memory ports.
- `clk` in 1: single clock; memory writes commit on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0`, `req1` in 1: transaction request. All request fields must be held stable until the matching `ack`.
- `we0`, `we1` in 1: 1 = write, 0 = read.
- `addr0`, `addr1` in `ADDR_W`: byte address; bits [1:0] are ignored.
- `wdata0`, `wdata1` in 32: write data; byte k = bits [8k+7:8k].
- `be0`, `be1` in 4: byte enables, used for writes only.
- `ack0`, `ack1` out 1: one-cycle completion pulse.
- `rdata0`, `rdata1` out 32: read data, registered. Valid from `ack` onward; updated only by reads.
- `mem_we` out 1: write enable to the memory.
- `mem_a` out `ADDR_W`: memory address, always with [1:0] = 00.
- `mem_wd` out 32: memory write data.
- `mem_rd` in 32: memory read data, combinational from `mem_a`.
- `busy` out 1: state != IDLE.
- `owner` out 1: index of the requester currently or most recently granted.

## Operation
- FSM states: IDLE, XFER, RMW_RD, RMW_WR.
- **IDLE arbitration**
  - Eligible requesters: `reqN`=1 and `ackN`=0 in the current cycle. This stops the request being acked from being re-granted.
  - One eligible requester: it is granted.
  - Two eligible requesters: grant the one that is not `last`. `last` then updates to the granted index.
  - On grant, latch we/addr/wdata/be and the index into registers. The memory side is driven only from these registers.
- **Transition out of IDLE**
  - Partial write (we=1, be not 1111 and not 0000) goes to RMW_RD.
  - Everything else goes to XFER.
- **XFER**
  - `mem_a` = latched address with [1:0] cleared.
  - Full write (be=1111): `mem_we`=1, `mem_wd`=wdata.
  - Write with be=0000: no-op, `mem_we`=0.
  - Read: `mem_rd` is captured into `rdataN` at the cycle end.
  - Then go to IDLE with `ackN`=1.
- **RMW_RD**
  - `mem_we`=0 while `mem_a` is driven; `mem_rd` is captured into the merge register.
  - Then go to RMW_WR.
- **RMW_WR**
  - `mem_we`=1.
  - `mem_wd` byte k = be[k] ? wdata byte k : merge byte k.
  - Then go to IDLE with `ackN`=1.
- `mem_we` is high only in XFER for a full write or in RMW_WR. It is decoded from the state and latched fields, so reset forces it low at once.
- In non-write states `mem_wd` holds its last value and has no meaning.

## Timing
- **Reset values:** state IDLE, `ack0`/`ack1` 0, `rdata0`/`rdata1` 0, `mem_we` 0, `mem_a` 0, `mem_wd` 0, `busy` 0, `owner` 0, `last` 1 (requester 0 wins the first contest).
- **Latency:** request sampled in IDLE at cycle 0.
  - Read, full write or be=0 write: memory access in cycle 1, `ack` in cycle 2.
  - Partial write: RMW_RD in cycle 1, RMW_WR in cycle 2, `ack` in cycle 3.
- **Ack cycle:** the FSM is in IDLE and may grant the other requester in that same cycle. The acked requester can be granted again at the earliest in cycle 3.
- **Throughput:** one memory access or RMW pair per grant, and at most one transaction in flight.
- **Dropped request:** if a requester drops `req` after grant, the latched transaction still completes and acks.
- **Reset mid-transaction:** the transaction aborts with no ack. If reset occurs before the RMW_WR clock edge, memory is not modified.
- **Address:** `mem_a` wraps naturally at `ADDR_W`. There is no range check.

## Test plan
- Memory[0x10]=0xDEADBEEF; req0 reads addr 0x12 → cycle 1 `mem_a`=0x10 with `mem_we`=0; cycle 2 `ack0`=1 and `rdata0`=0xDEADBEEF; `ack1` stays 0.
- Immediately after reset, req0 and req1 both read → `ack0` at cycle 2; req1 granted in cycle 2; `ack1` at cycle 4; `owner` 0 then 1.
- Memory[0x20]=0x11223344; req1 writes 0xAABBCCDD with be=0101 → `mem_we` high only in cycle 2 with `mem_wd`=0x11BB33DD; `ack1` at cycle 3; `rdata1` unchanged.
- Both `req` held high for 6 transactions → acks alternate 0,1,0,1,0,1; no requester is served twice in a row.
- req0 write with be=0000 → `ack0` at cycle 2; `mem_we` never asserted; memory unchanged.
- Partial write, `rst_n` pulled low during RMW_WR → `mem_we` drops immediately; the target word is unchanged; no ack; all outputs at reset values.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of the data-memory arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' and memory's view.
interface dmem_arbiter_if #(parameter int ADDR_W = 32);
    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [31:0]       wdata0, wdata1;
    logic [3:0]        be0, be1;
    logic              ack0, ack1;
    logic [31:0]       rdata0, rdata1;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_a;
    logic [31:0]       mem_wd;
    logic [31:0]       mem_rd;
    logic              busy;
    logic              owner;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, be0, be1, mem_rd,
        output ack0, ack1, rdata0, rdata1, mem_we, mem_a, mem_wd, busy, owner
    );
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, be0, be1, mem_rd,
        input  ack0, ack1, rdata0, rdata1, mem_we, mem_a, mem_wd, busy, owner
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for two requesters in front of a single-port word memory.
// Sub-word stores are performed as a read-modify-write pair.
module dmem_arbiter #(
    parameter int ADDR_W = 32
) (
    input logic          clk,
    input logic          rst_n,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, XFER, RMW_RD, RMW_WR} state_t;

    state_t              state, state_nxt;
    logic                l_we, l_idx;
    logic [ADDR_W-3:0]   l_word;
    logic [31:0]         l_wdata, merge, wd_hold, mem_wd_c;
    logic [3:0]          l_be;
    logic                last, owner_q;
    logic [1:0]          ack_q, elig;
    logic [31:0]         rdata0_q, rdata1_q;
    logic                grant_vld, grant_idx, g_we, g_part, done;
    logic [3:0]          g_be;

    // A requester being acked this cycle is not eligible, so it cannot be re-granted at once.
    always_comb begin
        elig      = {bus.req1 & ~ack_q[1], bus.req0 & ~ack_q[0]};
        grant_vld = |elig;
        grant_idx = (&elig) ? ~last : elig[1];
        g_we      = grant_idx ? bus.we1 : bus.we0;
        g_be      = grant_idx ? bus.be1 : bus.be0;
        g_part    = g_we && (g_be != 4'hF) && (g_be != 4'h0);
        done      = (state == XFER) || (state == RMW_WR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = g_part ? RMW_RD : XFER;
            XFER:    state_nxt = IDLE;
            RMW_RD:  state_nxt = RMW_WR;
            RMW_WR:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Write data is only meaningful in write states; otherwise it holds the last driven value.
    always_comb begin
        mem_wd_c = wd_hold;
        if (state == XFER && l_we && l_be == 4'hF)
            mem_wd_c = l_wdata;
        else if (state == RMW_WR)
            for (int k = 0; k < 4; k++)
                mem_wd_c[8*k +: 8] = l_be[k] ? l_wdata[8*k +: 8] : merge[8*k +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_we     <= 1'b0;
            l_idx    <= 1'b0;
            l_word   <= '0;
            l_wdata  <= '0;
            l_be     <= '0;
            last     <= 1'b1;
            owner_q  <= 1'b0;
            ack_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            merge    <= '0;
            wd_hold  <= '0;
        end else begin
            ack_q   <= '0;
            wd_hold <= mem_wd_c;
            if (state == IDLE && grant_vld) begin
                l_idx   <= grant_idx;
                l_we    <= g_we;
                l_be    <= g_be;
                l_word  <= grant_idx ? bus.addr1[ADDR_W-1:2] : bus.addr0[ADDR_W-1:2];
                l_wdata <= grant_idx ? bus.wdata1 : bus.wdata0;
                last    <= grant_idx;
                owner_q <= grant_idx;
            end
            if (state == XFER && !l_we) begin
                if (l_idx) rdata1_q <= bus.mem_rd;
                else       rdata0_q <= bus.mem_rd;
            end
            if (state == RMW_RD) merge <= bus.mem_rd;
            if (done) ack_q[l_idx] <= 1'b1;
        end
    end

    assign bus.mem_we = ((state == XFER) && l_we && (l_be == 4'hF)) || (state == RMW_WR);
    assign bus.mem_a  = {l_word, 2'b00};
    assign bus.mem_wd = mem_wd_c;
    assign bus.ack0   = ack_q[0];
    assign bus.ack1   = ack_q[1];
    assign bus.rdata0 = rdata0_q;
    assign bus.rdata1 = rdata1_q;
    assign bus.busy   = (state != IDLE);
    assign bus.owner  = owner_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected acks, a negedge monitor checks them.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic preload = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    typedef struct {
        bit          idx;
        logic [31:0] rd;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    logic [31:0] mem [0:255];

    dmem_arbiter_if #(.ADDR_W(32)) bus();

    dmem_arbiter #(.ADDR_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: combinational read, write on the rising edge.
    assign bus.mem_rd = mem[bus.mem_a[9:2]];
    always @(posedge clk) begin
        if (preload) begin
            mem[4] <= 32'hDEADBEEF;
            mem[8] <= 32'h11223344;
        end else if (bus.mem_we) begin
            mem[bus.mem_a[9:2]] <= bus.mem_wd;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (bus.ack0 || bus.ack1) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_idx", {30'd0, bus.ack1, bus.ack0}, mon_e.idx ? 32'd2 : 32'd1);
                chk("ack_rdata", mon_e.idx ? bus.rdata1 : bus.rdata0, mon_e.rd);
                chk("ack_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic drive(input bit idx, input bit we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        if (idx) begin
            bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd; bus.be1 = be; bus.req1 = 1'b1;
        end else begin
            bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd; bus.be0 = be; bus.req0 = 1'b1;
        end
    endtask

    task automatic expect_ack(input bit idx, input logic [31:0] rd, input int at);
        exp_t e;
        e.idx = idx; e.rd = rd; e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int c;
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        bus.be0 = '0; bus.be1 = '0;

        // Reset values
        step(3);
        chk("rst_ack0", bus.ack0, 0);
        chk("rst_ack1", bus.ack1, 0);
        chk("rst_rdata0", bus.rdata0, 0);
        chk("rst_rdata1", bus.rdata1, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_a", bus.mem_a, 0);
        chk("rst_mem_wd", bus.mem_wd, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_owner", bus.owner, 0);
        rst_n = 1'b1; preload = 1'b0;

        // Both read right after reset: requester 0 wins, then 1
        step(1); c = cyc;
        drive(0, 0, 32'h12, 0, 0);
        drive(1, 0, 32'h20, 0, 0);
        expect_ack(0, 32'hDEADBEEF, c + 2);
        expect_ack(1, 32'h11223344, c + 4);
        step(1);
        chk("rd_mem_a", bus.mem_a, 32'h10);
        chk("rd_mem_we", bus.mem_we, 0);
        chk("rd_owner0", bus.owner, 0);
        chk("rd_busy", bus.busy, 1);
        step(1); #1 bus.req0 = 0;
        step(1);
        chk("rd_owner1", bus.owner, 1);
        chk("rd_mem_a1", bus.mem_a, 32'h20);
        step(1); #1 bus.req1 = 0;

        // Partial write by requester 1: read-modify-write
        step(1); c = cyc;
        drive(1, 1, 32'h20, 32'hAABBCCDD, 4'b0101);
        expect_ack(1, 32'h11223344, c + 3);
        step(1);
        chk("rmw_rd_we", bus.mem_we, 0);
        chk("rmw_rd_a", bus.mem_a, 32'h20);
        step(1);
        chk("rmw_wr_we", bus.mem_we, 1);
        chk("rmw_wr_wd", bus.mem_wd, 32'h11BB33DD);
        step(1); #1 bus.req1 = 0;
        chk("rmw_ack_we", bus.mem_we, 0);
        chk("rmw_mem", mem[8], 32'h11BB33DD);

        // Full write by requester 0, then requester 1 reads it back
        step(1); c = cyc;
        drive(0, 1, 32'h30, 32'hCAFEF00D, 4'hF);
        expect_ack(0, 32'hDEADBEEF, c + 2);
        step(1);
        chk("fw_we", bus.mem_we, 1);
        chk("fw_wd", bus.mem_wd, 32'hCAFEF00D);
        chk("fw_a", bus.mem_a, 32'h30);
        step(1); #1 bus.req0 = 0;
        step(1); c = cyc;
        drive(1, 0, 32'h33, 0, 0);
        expect_ack(1, 32'hCAFEF00D, c + 2);
        step(2); #1 bus.req1 = 0;

        // Both held for six transactions: strict alternation starting at 0
        step(1); c = cyc;
        drive(0, 0, 32'h10, 0, 0);
        drive(1, 0, 32'h20, 0, 0);
        for (int i = 0; i < 6; i++)
            expect_ack(i[0], i[0] ? 32'h11BB33DD : 32'hDEADBEEF, c + 2 + 2 * i);
        step(12); #1 begin bus.req0 = 0; bus.req1 = 0; end

        // be=0000 write is a no-op that still acks
        step(1); c = cyc;
        drive(0, 1, 32'h10, 32'h12345678, 4'b0000);
        expect_ack(0, 32'hDEADBEEF, c + 2);
        chk("be0_we_c0", bus.mem_we, 0);
        step(1);
        chk("be0_we_c1", bus.mem_we, 0);
        step(1); #1 bus.req0 = 0;
        chk("be0_we_c2", bus.mem_we, 0);
        chk("be0_mem", mem[4], 32'hDEADBEEF);

        // Reset during RMW_WR: no write, no ack, outputs back to reset values
        step(1);
        drive(0, 1, 32'h20, 32'h00000000, 4'b0001);
        step(2);
        chk("rstmid_we_before", bus.mem_we, 1);
        chk("rstmid_wd_before", bus.mem_wd, 32'h11BB3300);
        rst_n = 1'b0;
        #1;
        chk("rstmid_we", bus.mem_we, 0);
        chk("rstmid_busy", bus.busy, 0);
        chk("rstmid_mem_a", bus.mem_a, 0);
        chk("rstmid_mem_wd", bus.mem_wd, 0);
        chk("rstmid_owner", bus.owner, 0);
        chk("rstmid_rdata0", bus.rdata0, 0);
        chk("rstmid_rdata1", bus.rdata1, 0);
        bus.req0 = 0;
        step(2);
        chk("rstmid_mem", mem[8], 32'h11BB33DD);
        chk("rstmid_ack0", bus.ack0, 0);
        rst_n = 1'b1;
        step(4);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
